// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: the NOOP word, the major
// opcodes, the PC stride and the queue entry format that pairs a word with
// its address.
package mips_pkg;

  localparam logic [31:0] NOOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADD_IMM = 6'h08;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between the instruction memory and decode. The depth is a
// power of two, so the read and write pointers wrap on their own. A flush
// empties the queue in one cycle without touching the storage.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rptr_q, wptr_q;
  logic [AW:0]    count_q;

  // Storage holds data only, so it is written without reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush takes precedence over push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch front end. Issues word fetches while credit remains
// (in-flight plus queued words below DEPTH), buffers in-order responses in
// the prefetch queue and presents the head to decode. A redirect flushes the
// queue, retargets fetch and marks every still-owed response as stale.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOOP     = NOOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count;
  logic [CW:0]   credit_sum;
  logic          fire, rsp, push, pop;
  fetch_entry_t  head, wdata;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp        = imem_rvalid && (inflight_q != '0);
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count};
  assign imem_req   = !reset && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc_q;
  assign fire       = imem_req && imem_gnt;
  assign push       = rsp && !redirect_valid && (drop_cnt_q == '0);
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign wdata      = '{pc: resp_pc_q, instr: imem_rdata};

  assign if_valid   = (count != '0);
  assign if_instr   = if_valid ? head.instr : NOOP;
  assign if_pc      = if_valid ? head.pc : 32'h0;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

  // Next-state for fetch/response PCs, in-flight tracking and stale drops.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CW'(fire) - CW'(rsp);
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      drop_cnt_d = inflight_q - CW'(rsp);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (push) resp_pc_d = resp_pc_q + PC_INC;
      if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: an in-order memory model with configurable
// latency, and a scoreboard of expected {pc, instr} pairs filled on grant,
// cleared on redirect/reset and checked on every pop.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  always #5 clock = ~clock;

  mips_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOOP(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_ready       (if_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  model_pc;
  logic [31:0]  last_pop_pc;
  logic         last_pop;
  logic         release_rst;
  logic         gnt_en;
  logic         found;
  int           cyc, lat, outst, grants;
  int           vectors, miscompares;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    fetch_entry_t e;
    pend_t        p;
    logic         popped;
    @(negedge clock);
    if (release_rst) begin
      reset       = 1'b0;
      release_rst = 1'b0;
    end
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      assert (outst > 0) else $error("FAIL rsp_without_request: outstanding %0d", outst);
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
      pend_q.delete(0);
      outst--;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = gnt_en;
    #1;
    if (!if_valid) begin
      check_eq("idle_instr", if_instr, NOOP_WORD);
      check_eq("idle_pc", if_pc, 32'h0);
    end
    if (redir) check_eq("req_in_redirect", {31'b0, imem_req}, 32'h0);
    if (imem_req) check_eq("imem_addr", imem_addr, model_pc);
    popped   = if_valid && rdy && !redir;
    last_pop = popped;
    if (popped) begin
      last_pop_pc = if_pc;
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {31'b0, if_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pop_pc", if_pc, e.pc);
        check_eq("pop_instr", if_instr, e.instr);
      end
    end
    if (imem_req && imem_gnt) begin
      p.addr = imem_addr;
      p.due  = cyc + lat;
      pend_q.push_back(p);
      exp_q.push_back(fetch_entry_t'{pc: model_pc, instr: mem_word(model_pc)});
      model_pc += 32'd4;
      grants++;
      outst++;
    end
    if (redir) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end
  endtask

  // Memory side is reset together with the DUT: nothing outstanding survives.
  task automatic clear_models(input int l);
    pend_q.delete();
    exp_q.delete();
    model_pc       = 32'h0;
    outst          = 0;
    lat            = l;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    gnt_en         = 1'b1;
  endtask

  task automatic do_reset(input int l);
    @(negedge clock);
    reset = 1'b1;
    clear_models(l);
    @(negedge clock);
    release_rst = 1'b1;
  endtask

  task automatic wait_pop(input string tag);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (last_pop) found = 1'b1;
    end
    check_eq(tag, {31'b0, found}, 32'h1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    grants      = 0;
    release_rst = 1'b0;
    last_pop    = 1'b0;
    last_pop_pc = 32'h0;
    reset       = 1'b1;
    redirect_pc = 32'h0;
    imem_rdata  = 32'h0;
    imem_gnt    = 1'b1;
    clear_models(1);
    #1;
    check_eq("rst_valid", {31'b0, if_valid}, 32'h0);
    check_eq("rst_instr", if_instr, NOOP_WORD);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);

    // Streaming from reset with a 1-cycle memory.
    do_reset(1);
    step(1'b1, 1'b0, 32'h0);
    check_eq("lat_c0_valid", {31'b0, if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check_eq("lat_c1_valid", {31'b0, if_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check_eq("stream_valid", {31'b0, if_valid}, 32'h1);
      check_eq("stream_pc", if_pc, 32'(i * 4));
    end

    // Decode stall: credit runs out after DEPTH grants, head holds.
    do_reset(1);
    grants = 0;
    repeat (10) begin
      step(1'b0, 1'b0, 32'h0);
      if (if_valid) check_eq("stall_head_pc", if_pc, 32'h0);
    end
    check_eq("stall_grants", 32'(grants), 32'(DEPTH));
    check_eq("stall_req_low", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check_eq("release_valid", {31'b0, if_valid}, 32'h1);
      check_eq("release_pc", if_pc, 32'(i * 4));
    end

    // Redirect with two responses owed by a 3-cycle memory.
    do_reset(3);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h40);
    wait_pop("redir3_seen");
    check_eq("redir3_first_pc", last_pop_pc, 32'h40);
    step(1'b1, 1'b0, 32'h0);
    check_eq("redir3_second_pc", if_pc, 32'h44);

    // Redirect in the same cycle as a response and a would-be pop.
    do_reset(1);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h103);
    step(1'b1, 1'b0, 32'h0);
    check_eq("flush_valid", {31'b0, if_valid}, 32'h0);
    check_eq("aligned_addr", imem_addr, 32'h100);
    wait_pop("redir1_seen");
    check_eq("redir1_first_pc", last_pop_pc, 32'h100);

    // Fetch address wraps past the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr_hi", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check_eq("wrap_addr_lo", imem_addr, 32'h0);
    wait_pop("wrap_seen");
    check_eq("wrap_first_pc", last_pop_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check_eq("wrap_second_pc", if_pc, 32'h0);

    // Asynchronous reset with words queued and in flight.
    do_reset(2);
    repeat (4) step(1'b0, 1'b0, 32'h0);
    check_eq("pre_rst_valid", {31'b0, if_valid}, 32'h1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_valid", {31'b0, if_valid}, 32'h0);
    check_eq("async_instr", if_instr, NOOP_WORD);
    check_eq("async_pc", if_pc, 32'h0);
    check_eq("async_req", {31'b0, imem_req}, 32'h0);
    clear_models(1);
    @(negedge clock);
    release_rst = 1'b1;
    wait_pop("restart_seen");
    check_eq("restart_pc", last_pop_pc, 32'h0);

    // Random grant and ready stutter against the scoreboard.
    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      gnt_en = 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 2) != 0), 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
